// File: rtl/pixel_stream_tx.sv
// Pixel-append transmitter: buffers 12-bit RGB pixels in a small FIFO and replays
// each one to the display as an addInput pulse, tracking the display write index.
module pixel_stream_tx #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 2,
  parameter int GAP   = 2,
  parameter int PW    = 40,
  parameter int PH    = 30
) (
  input  logic                       clk_50,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [11:0]                in_rgb,
  input  logic                       sync_req,
  output logic                       addInput,
  output logic [11:0]                rgbCode,
  output logic                       disp_reset,
  output logic [10:0]                pix_index,
  output logic                       frame_done,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int NPIX = PW * PH;
  localparam int CMAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ASSERT,
    S_GAP,
    S_SYNC
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            sync_latch;
  logic            pix_seq;
  logic [11:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic            fifo_empty;

  assign fifo_empty = (fifo_level == '0);
  assign in_ready   = (fifo_level != LW'(DEPTH));
  assign push       = in_valid && in_ready;
  // The sync latch outranks queued pixels, so a pop only happens when it is clear.
  assign pop        = (state == S_IDLE) && !sync_latch && !fifo_empty;
  assign busy       = (state != S_IDLE) || !fifo_empty || sync_latch;

  // FIFO storage holds data only, so it carries no reset.
  always_ff @(posedge clk_50) begin
    if (push) mem[wr_ptr] <= in_rgb;
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sync_latch <= 1'b0;
      pix_seq    <= 1'b0;
      addInput   <= 1'b0;
      rgbCode    <= '0;
      disp_reset <= 1'b0;
      pix_index  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      disp_reset <= 1'b0;
      if (sync_req) sync_latch <= 1'b1;
      case (state)
        S_IDLE: begin
          if (sync_latch) begin
            // A request arriving on this same edge is merged into the one being served.
            sync_latch <= 1'b0;
            disp_reset <= 1'b1;
            pix_index  <= '0;
            pix_seq    <= 1'b0;
            state      <= S_SYNC;
          end else if (!fifo_empty) begin
            rgbCode <= mem[rd_ptr];
            pix_seq <= 1'b1;
            state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          addInput <= 1'b1;
          cnt      <= '0;
          state    <= S_ASSERT;
        end
        S_ASSERT: begin
          if (cnt == CW'(HOLD - 1)) begin
            addInput <= 1'b0;
            cnt      <= '0;
            state    <= S_GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_SYNC: begin
          cnt   <= '0;
          state <= S_GAP;
        end
        S_GAP: begin
          if (cnt == CW'(GAP - 1)) begin
            state <= S_IDLE;
            if (pix_seq) begin
              if (pix_index == 11'(NPIX - 1)) begin
                pix_index  <= '0;
                frame_done <= 1'b1;
              end else begin
                pix_index <= pix_index + 11'd1;
              end
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Bench for pixel_stream_tx: directed scenarios plus random traffic, checked every
// cycle against a timeline model (queue of pixels + edge numbers of each action).
module tb_pixel_stream_tx;

  localparam int DEPTH = 4;
  localparam int HOLD  = 2;
  localparam int GAP   = 2;
  localparam int PW    = 40;
  localparam int PH    = 30;

  logic        clk_50;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_rgb;
  logic        sync_req;
  logic        addInput;
  logic [11:0] rgbCode;
  logic        disp_reset;
  logic [10:0] pix_index;
  logic        frame_done;
  logic        busy;
  logic [2:0]  fifo_level;

  pixel_stream_tx #(.DEPTH(DEPTH), .HOLD(HOLD), .GAP(GAP), .PW(PW), .PH(PH)) dut (
    .clk_50     (clk_50),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rgb     (in_rgb),
    .sync_req   (sync_req),
    .addInput   (addInput),
    .rgbCode    (rgbCode),
    .disp_reset (disp_reset),
    .pix_index  (pix_index),
    .frame_done (frame_done),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  int checks = 0;
  int errors = 0;
  int wraps  = 0;

  // Timeline model: each action is described by the edge it starts on.
  logic [11:0] q[$];
  int  n          = 0;
  int  busy_until = 0;
  int  act_kind   = 0;   // 0 none, 1 pixel, 2 sync
  int  act_edge   = 0;
  int  idx        = 0;
  int  exp_rgb    = 0;
  bit  exp_fd     = 0;
  bit  latch      = 0;
  bit  acc        = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic model(input bit v, input logic [11:0] rgb, input bit s, input bit r);
    bit idle_before;
    int sz;
    bit lat;
    n++;
    if (r) begin
      q.delete();
      latch = 0; busy_until = n; act_kind = 0; idx = 0;
      exp_rgb = 0; exp_fd = 0; acc = 0;
      return;
    end
    idle_before = (n > busy_until);
    sz  = q.size();
    lat = latch;
    exp_fd = 0;
    if (n == busy_until && act_kind == 1) begin
      if (idx == PW * PH - 1) begin idx = 0; exp_fd = 1; wraps++; end
      else idx++;
    end
    if (idle_before) begin
      if (lat) begin
        act_kind = 2; act_edge = n; busy_until = n + 1 + GAP; idx = 0; latch = 0;
      end else if (sz > 0) begin
        exp_rgb = q.pop_front();
        act_kind = 1; act_edge = n; busy_until = n + 1 + HOLD + GAP;
      end
    end
    if (s && !(idle_before && lat)) latch = 1;
    acc = v && (sz < DEPTH);
    if (acc) q.push_back(rgb);
  endtask

  task automatic compare();
    bit exp_add;
    bit exp_dr;
    bit exp_busy;
    exp_add  = (act_kind == 1) && (n >= act_edge + 1) && (n <= act_edge + HOLD);
    exp_dr   = (act_kind == 2) && (n == act_edge);
    exp_busy = !((n >= busy_until) && (q.size() == 0) && !latch);
    chk("addInput",   int'(addInput),   int'(exp_add));
    chk("rgbCode",    int'(rgbCode),    exp_rgb);
    chk("disp_reset", int'(disp_reset), int'(exp_dr));
    chk("pix_index",  int'(pix_index),  idx);
    chk("frame_done", int'(frame_done), int'(exp_fd));
    chk("busy",       int'(busy),       int'(exp_busy));
    chk("in_ready",   int'(in_ready),   int'(q.size() < DEPTH));
    chk("fifo_level", int'(fifo_level), q.size());
  endtask

  task automatic step(input bit v, input logic [11:0] rgb, input bit s, input bit r);
    in_valid = v; in_rgb = rgb; sync_req = s; reset = r;
    @(posedge clk_50);
    model(v, rgb, s, r);
    @(negedge clk_50);
    compare();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 12'h000, 0, 0);
  endtask

  initial begin
    in_valid = 0; in_rgb = '0; sync_req = 0; reset = 1;
    step(0, 12'h000, 0, 1);
    step(1, 12'h555, 0, 1);

    // Single pixel
    step(1, 12'hF80, 0, 0);
    idle(10);

    // Six pixels with valid held until each is accepted
    begin
      int pix = 1;
      for (int guard = 0; guard < 100 && pix <= 6; guard++) begin
        step(1, 12'(pix), 0, 0);
        if (acc) pix++;
      end
      if (pix <= 6) begin
        errors++;
        $display("FAIL six_pixels_accept got %0d want 7", pix);
      end
    end
    idle(40);

    // Sync request while 0x123 is in ASSERT
    step(1, 12'h123, 0, 0);
    step(1, 12'h200, 0, 0);
    step(1, 12'h201, 0, 0);
    step(0, 12'h000, 1, 0);
    idle(40);

    // Reset during ASSERT with three pixels queued
    step(1, 12'hA01, 0, 0);
    step(1, 12'hA02, 0, 0);
    step(1, 12'hA03, 0, 0);
    step(1, 12'hA04, 0, 0);
    step(0, 12'h000, 0, 1);
    idle(20);

    // Long random run without syncs so the index wraps past PW*PH-1
    for (int i = 0; i < 7600; i++)
      step(($urandom_range(3, 0) != 0), 12'($urandom()), 0, 0);
    if (wraps == 0) begin
      errors++;
      $display("FAIL frame_wrap got 0 wraps want >=1");
    end

    // Mixed random traffic with syncs and occasional resets
    for (int i = 0; i < 1500; i++)
      step($urandom_range(1, 0) == 1, 12'($urandom()),
           $urandom_range(39, 0) == 0, $urandom_range(499, 0) == 0);
    idle(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_stream_tx.md
Name: pixel_stream_tx

Overview:
- Transmitter side of the display's pixel-append interface.
- Accepts 12-bit RGB pixels from the CPU/IO side over a valid/ready handshake and buffers them in a small FIFO.
- Replays each pixel to the display's image block as one `addInput` pulse with a stable `rgbCode`. A low gap follows every pulse, because the display only accepts one pixel per rising-edge of `addInput`.
- Tracks the display's write index (0..PW*PH-1) and can resynchronise the display by issuing a one-cycle display reset.

Parameters:
- DEPTH, 4: FIFO entries; must be a power of 2, minimum 2.
- HOLD, 2: cycles `addInput` stays high per pixel; minimum 1.
- GAP, 2: cycles `addInput` stays low after each pulse; minimum 1.
- PW, 40: display map width in cells.
- PH, 30: display map height in cells.

Ports:
- `clk_50`, input, 1: clock; shared with the display's write side.
- `reset`, input, 1: synchronous, active-high.
- `in_valid`, input, 1: source presents a pixel.
- `in_ready`, output, 1: FIFO can accept; equals !full.
- `in_rgb`, input, 12: pixel as {R[11:8], G[7:4], B[3:0]}.
- `sync_req`, input, 1: request to restart the display frame at index 0.
- `addInput`, output, 1: pixel strobe to the display.
- `rgbCode`, output, 12: pixel to the display; stable for the whole pulse.
- `disp_reset`, output, 1: one-cycle reset to the display image block.
- `pix_index`, output, 11: index the display writes next.
- `frame_done`, output, 1: one-cycle pulse when `pix_index` wraps.
- `busy`, output, 1: FSM not in IDLE, or FIFO not empty.
- `fifo_level`, output, clog2(DEPTH)+1: current FIFO occupancy.

Behaviour:
- Reset values: all outputs 0 except `in_ready`=1; FIFO empty; FSM in IDLE; `sync_req` latch cleared.
- Reset mid-pulse: `addInput` is low from the next cycle; the queued pixels and the pending sync are discarded.
- FIFO push: `in_valid && in_ready` at the rising edge.
  - No bypass: a pixel pushed into an empty FIFO becomes visible to the FSM on the next cycle.
  - While full, `in_ready`=0 and `in_valid` is ignored.
- FSM states:
  - IDLE: chooses the next action (see priority below).
  - SETUP: 1 cycle, `addInput`=0, `rgbCode` already holds the new pixel.
  - ASSERT: HOLD cycles, `addInput`=1.
  - GAP: GAP cycles, `addInput`=0.
  - SYNC: 1 cycle, `disp_reset`=1.
- IDLE priority:
  - If the sync latch is set, go to SYNC.
  - Else if the FIFO is non-empty, pop the head into the `rgbCode` register and go to SETUP.
  - Else stay in IDLE.
- Sequences:
  - Pixel: SETUP -> ASSERT -> GAP -> IDLE.
  - Sync: SYNC -> GAP -> IDLE.
- `sync_req`: a one-cycle pulse sets a sticky latch. The latch clears on entry to SYNC, so an in-flight pixel always completes before the sync. Extra `sync_req` pulses while the latch is set are merged into it.
- Latency: a pixel pushed at edge E into an empty FIFO with the FSM in IDLE is popped at E+1, and `addInput` rises at edge E+2.
  - Pixel period: 2+HOLD+GAP cycles including the IDLE cycle, i.e. 6 cycles at defaults.
  - `rgbCode` changes only on a pop and is otherwise held.
- `pix_index` advances on the GAP->IDLE transition of a pixel sequence:
  - If the index equals PW*PH-1 it wraps to 0 and `frame_done` pulses in the same cycle.
  - Otherwise it increments by 1.
- SYNC sets `pix_index` to 0 and does not pulse `frame_done`. FIFO contents are preserved across a sync.
- `fifo_level`: a simultaneous push and pop leaves the level unchanged.
- `busy`=0 only when the FSM is in IDLE, the FIFO is empty and the sync latch is clear.

Test Plan:
- Reset, then push 0xF80 once -> `addInput` is high for exactly 2 cycles starting 2 edges after the push; `rgbCode`=0xF80 throughout; `pix_index` goes 0->1; `busy` returns to 0.
- Hold `in_valid` for 6 pixels (0x001..0x006) with DEPTH=4 -> `in_ready` drops once 4 are queued; all 6 pulses appear in order, spaced 6 cycles apart; no pixel is lost or duplicated.
- Preload `pix_index`=1198, then send 3 pixels -> index goes 1199 -> 0 with a 1-cycle `frame_done` -> 1.
- Pulse `sync_req` during ASSERT of pixel 0x123 -> that pulse still completes with HOLD=2; `disp_reset` pulses 1 cycle after GAP; `pix_index`=0; queued pixels then resume output.
- Assert `reset` during ASSERT with 3 pixels queued -> `addInput` is 0 the next cycle; `fifo_level`=0; `pix_index`=0; nothing further is emitted.
- Push and pop in the same cycle at `fifo_level`=2 -> the level stays 2; FIFO order is preserved.
